calendar_step_ctrl: RTL

//  Sequencer for the calendar counter chain (day -> month -> year). Arbitrates midnight

---
 rtl/calendar_step_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/calendar_step_ctrl.sv
// Sequencer for the day/month/year counter chain: arbitrates midnight rollovers against set-mode buttons.
// Latency: midnight to day_en is 2 cycles (latch, grant); each link is PULSE_W+SETTLE_W+1 cycles.
// Backpressure: midnights queue in a saturating counter (sticky overflow_err); button requests queue as pending bits.
module calendar_step_ctrl #(
  parameter int PULSE_W  = 1,
  parameter int SETTLE_W = 2,
  parameter int PEND_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic midnight,
  input  logic set_mode,
  input  logic btn_day,
  input  logic btn_month,
  input  logic btn_year,
  input  logic end_of_month,
  input  logic end_of_year,
  output logic day_en,
  output logic day_off,
  output logic month_en,
  output logic month_off,
  output logic year_en,
  output logic busy,
  output logic overflow_err
);

  localparam int CNT_MAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;
  typedef enum logic [2:0] {
    SEL_DAY_EN, SEL_DAY_OFF, SEL_MONTH_EN, SEL_MONTH_OFF, SEL_YEAR_EN
  } sel_t;

  state_t           state, state_nxt;
  sel_t             sel, sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       pend_cnt;
  logic [2:0]       pend_sum;
  logic [2:0]       btn_q;
  logic [2:0]       btn_edge;
  logic [2:0]       btn_pend;
  logic [2:0]       grant_btn;
  logic             grant_chain;

  assign btn_edge = {btn_year, btn_month, btn_day} & ~btn_q;
  assign pend_sum = {1'b0, pend_cnt} + {2'b00, midnight} - {2'b00, grant_chain};

  // Next-state logic: grant in IDLE, time the pulse and settle phases, follow carries in CHECK.
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    cnt_nxt     = cnt;
    grant_chain = 1'b0;
    grant_btn   = 3'b000;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pend_cnt != 2'd0) begin
          grant_chain = 1'b1;
          sel_nxt     = SEL_DAY_EN;
          state_nxt   = PULSE;
        end else if (btn_pend[0]) begin
          grant_btn[0] = 1'b1;
          sel_nxt      = SEL_DAY_OFF;
          state_nxt    = PULSE;
        end else if (btn_pend[1]) begin
          grant_btn[1] = 1'b1;
          sel_nxt      = SEL_MONTH_OFF;
          state_nxt    = PULSE;
        end else if (btn_pend[2]) begin
          grant_btn[2] = 1'b1;
          sel_nxt      = SEL_YEAR_EN;
          state_nxt    = PULSE;
        end
      end
      PULSE: begin
        if (cnt == CNT_W'(PULSE_W - 1)) begin
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == CNT_W'(SETTLE_W - 1)) begin
          cnt_nxt   = '0;
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CHECK: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
        if (sel == SEL_DAY_EN && end_of_month) begin
          sel_nxt   = SEL_MONTH_EN;
          state_nxt = PULSE;
        end else if (sel == SEL_MONTH_EN && end_of_year) begin
          sel_nxt   = SEL_YEAR_EN;
          state_nxt = PULSE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered output decode of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= SEL_DAY_EN;
      cnt       <= '0;
      day_en    <= 1'b0;
      day_off   <= 1'b0;
      month_en  <= 1'b0;
      month_off <= 1'b0;
      year_en   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      cnt       <= cnt_nxt;
      day_en    <= (state_nxt == PULSE) && (sel_nxt == SEL_DAY_EN);
      day_off   <= (state_nxt == PULSE) && (sel_nxt == SEL_DAY_OFF);
      month_en  <= (state_nxt == PULSE) && (sel_nxt == SEL_MONTH_EN);
      month_off <= (state_nxt == PULSE) && (sel_nxt == SEL_MONTH_OFF);
      year_en   <= (state_nxt == PULSE) && (sel_nxt == SEL_YEAR_EN);
      // Covers the grant cycle through the final CHECK cycle of the operation.
      busy      <= (state != IDLE) || (state_nxt != IDLE);
    end
  end

  // Request capture: midnight counter with saturation, button edges gated by set_mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_cnt     <= 2'd0;
      overflow_err <= 1'b0;
      btn_q        <= 3'b000;
      btn_pend     <= 3'b000;
    end else begin
      btn_q    <= {btn_year, btn_month, btn_day};
      btn_pend <= set_mode ? ((btn_pend & ~grant_btn) | btn_edge) : 3'b000;
      pend_cnt <= (pend_sum > 3'(PEND_MAX)) ? 2'(PEND_MAX) : pend_sum[1:0];
      if (midnight && (pend_cnt == 2'(PEND_MAX))) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule
